easy_fifo_axis_reader: RTL and testbench



---
 rtl/easy_fifo_axis_reader.sv | 106 ++++++++++
 tb/tb_easy_fifo_axis_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/easy_fifo_axis_reader.sv
// Bridges a native fixed-latency FIFO read port to an AXI-Stream master via a small prefetch buffer.
// Optional stall counter output enabled by EASY_FIFO_AXIS_READER_STALL_CNT_EN.
module easy_fifo_axis_reader #(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned BUF_DEPTH = RD_LATENCY + 2,
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_rd_data,
    input  logic              fifo_rd_empty,
    output logic [DWIDTH-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [CNT_W-1:0]  buf_cnt
`ifdef EASY_FIFO_AXIS_READER_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("easy_fifo_axis_reader: RD_LATENCY must be 1 or 2");
    end

    logic                  run;
    logic [RD_LATENCY-1:0] inflight;
    logic [CNT_W-1:0]      occ;
    logic [CNT_W-1:0]      n_inflight;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DWIDTH-1:0]     mem [BUF_DEPTH];
    logic                  wr;
    logic                  pop;
    logic                  issue_room;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Number of reads still travelling through the FIFO read pipeline.
    always_comb begin
        n_inflight = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            n_inflight = n_inflight + CNT_W'(inflight[i]);
        end
    end

    // Issue only while every outstanding word is guaranteed a free entry, independent of tready.
    assign issue_room    = (SUM_W'(occ) + SUM_W'(n_inflight)) <= SUM_W'(BUF_DEPTH - 2);
    assign fifo_rd_en    = run & ~fifo_rd_empty & issue_room;
    assign wr            = inflight[RD_LATENCY-1];
    assign m_axis_tvalid = (occ != '0);
    assign m_axis_tdata  = mem[rd_ptr];
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign buf_cnt       = occ;

    // Control state; run holds off reads for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run      <= 1'b0;
            inflight <= '0;
            occ      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            run      <= 1'b1;
            inflight <= RD_LATENCY'({inflight, fifo_rd_en});
            occ      <= occ + CNT_W'(wr) - CNT_W'(pop);
            if (wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Prefetch storage, cleared on reset so tdata reads 0 until a word lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr) begin
            mem[wr_ptr] <= fifo_rd_data;
        end
    end

`ifdef EASY_FIFO_AXIS_READER_STALL_CNT_EN
    // Saturating count of cycles where a beat is offered but not taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (m_axis_tvalid && !m_axis_tready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_easy_fifo_axis_reader.sv
// Self-checking bench: one DUT per legal read latency, each fed by a behavioural FIFO and scored
// against a timestamp-based occupancy / ordering model.
module tb_easy_fifo_axis_reader;

    logic        clk;
    logic        rst;
    logic        rd_en    [2];
    logic [31:0] rd_data  [2];
    logic        empty    [2];
    logic [31:0] tdata    [2];
    logic        tvalid   [2];
    logic        tready   [2];
    logic [1:0]  bc1;
    logic [2:0]  bc2;
`ifdef EASY_FIFO_AXIS_READER_STALL_CNT_EN
    logic [31:0] sc       [2];
    int          stall_exp[2];
`endif

    easy_fifo_axis_reader #(.DWIDTH(32), .RD_LATENCY(1)) u_dut_l1 (
        .clk           (clk),
        .rst           (rst),
        .fifo_rd_en    (rd_en[0]),
        .fifo_rd_data  (rd_data[0]),
        .fifo_rd_empty (empty[0]),
        .m_axis_tdata  (tdata[0]),
        .m_axis_tvalid (tvalid[0]),
        .m_axis_tready (tready[0]),
        .buf_cnt       (bc1)
`ifdef EASY_FIFO_AXIS_READER_STALL_CNT_EN
        ,
        .stall_cnt     (sc[0])
`endif
    );

    easy_fifo_axis_reader #(.DWIDTH(32), .RD_LATENCY(2)) u_dut_l2 (
        .clk           (clk),
        .rst           (rst),
        .fifo_rd_en    (rd_en[1]),
        .fifo_rd_data  (rd_data[1]),
        .fifo_rd_empty (empty[1]),
        .m_axis_tdata  (tdata[1]),
        .m_axis_tvalid (tvalid[1]),
        .m_axis_tready (tready[1]),
        .buf_cnt       (bc2)
`ifdef EASY_FIFO_AXIS_READER_STALL_CNT_EN
        ,
        .stall_cnt     (sc[1])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          total;
    int          bad;
    int          n;
    int          since;
    int          issued   [2];
    int          arrived  [2];
    int          accepted [2];
    int          avail    [2];
    int          issue_cyc[2][0:1023];
    logic [31:0] mem      [2][0:1023];
    bit          mark_on  [2];
    int          mark_n   [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int d);
        return d + 1;
    endfunction

    function automatic int bcnt(input int d);
        return (d == 0) ? int'(bc1) : int'(bc2);
    endfunction

    task automatic push(input logic [31:0] v);
        for (int d = 0; d < 2; d++) begin
            mem[d][avail[d]] = v;
            avail[d]++;
            empty[d] = (issued[d] >= avail[d]);
        end
    endtask

    task automatic set_ready(input logic v);
        tready[0] = v;
        tready[1] = v;
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        since = 0;
        for (int d = 0; d < 2; d++) begin
            accepted[d] = issued[d];
            arrived[d]  = issued[d];
`ifdef EASY_FIFO_AXIS_READER_STALL_CNT_EN
            stall_exp[d] = 0;
`endif
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance FIFO and model past the edge.
    task automatic step();
        bit pop_s [2];
        bit acc_s [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int eo;
            int ei;
            bit ev;
            bit er;
            string p;
            p  = $sformatf("L%0d", lat(d));
            eo = arrived[d] - accepted[d];
            ei = issued[d] - arrived[d];
            ev = (eo != 0);
            er = rst && (since >= 1) && (issued[d] < avail[d]) && (eo + ei <= lat(d) + 2 - 2);
            check({p, " rd_en"}, 64'(rd_en[d]), 64'(er));
            check({p, " tvalid"}, 64'(tvalid[d]), 64'(ev));
            check({p, " buf_cnt"}, 64'(bcnt(d)), 64'(eo));
            if (ev) check({p, " tdata"}, 64'(tdata[d]), 64'(mem[d][accepted[d]]));
            if (!rst) check({p, " tdata_rst"}, 64'(tdata[d]), 64'd0);
`ifdef EASY_FIFO_AXIS_READER_STALL_CNT_EN
            check({p, " stall_cnt"}, 64'(sc[d]), 64'(stall_exp[d]));
            if (ev && !tready[d]) stall_exp[d]++;
`endif
            if (mark_on[d] && tvalid[d]) begin
                mark_n[d]  = n;
                mark_on[d] = 1'b0;
            end
            pop_s[d] = rd_en[d] && (issued[d] < avail[d]);
            acc_s[d] = ev && tready[d];
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (pop_s[d]) begin
                issue_cyc[d][issued[d]] = n;
                issued[d]++;
            end
            if (acc_s[d]) accepted[d]++;
        end
        n++;
        for (int d = 0; d < 2; d++) begin
            while (arrived[d] < issued[d] && issue_cyc[d][arrived[d]] + lat(d) + 1 <= n) arrived[d]++;
            rd_data[d] = $urandom;
            for (int k = issued[d] - 1; k >= 0 && k >= issued[d] - 4; k--) begin
                if (issue_cyc[d][k] == n - lat(d)) rd_data[d] = mem[d][k];
            end
            empty[d] = (issued[d] >= avail[d]);
        end
        if (rst) since++;
    endtask

    task automatic drain(input string tag);
        set_ready(1'b1);
        for (int i = 0; i < 400 && (accepted[0] != avail[0] || accepted[1] != avail[1]); i++) step();
        step();
        check({tag, " L1 drained"}, 64'(accepted[0]), 64'(avail[0]));
        check({tag, " L2 drained"}, 64'(accepted[1]), 64'(avail[1]));
    endtask

    initial begin
        int ref_n;
        int pushed;
        total = 0;
        bad   = 0;
        n     = 0;
        since = 0;
        rst   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            issued[d] = 0; arrived[d] = 0; accepted[d] = 0; avail[d] = 0;
            empty[d] = 1'b1; rd_data[d] = '0; tready[d] = 1'b0;
            mark_on[d] = 1'b0; mark_n[d] = -1;
`ifdef EASY_FIFO_AXIS_READER_STALL_CNT_EN
            stall_exp[d] = 0;
`endif
        end
        repeat (3) step();

        // Streaming: FIFO preloaded with 0x00..0x0F, first beat after release timed.
        for (int i = 0; i < 16; i++) push(32'(i));
        set_ready(1'b1);
        rst   = 1'b1;
        ref_n = n;
        for (int d = 0; d < 2; d++) begin mark_on[d] = 1'b1; mark_n[d] = -1; end
        for (int i = 0; i < 20 && (mark_on[0] || mark_on[1]); i++) step();
        check("L1 first_beat", 64'(mark_n[0] - ref_n), 64'(3));
        check("L2 first_beat", 64'(mark_n[1] - ref_n), 64'(4));
        drain("stream");

        // Backpressure: 8 words held back by tready low, then released in order.
        set_ready(1'b0);
        for (int i = 0; i < 8; i++) push(32'(i));
        repeat (10) step();
        check("L1 bp buf_cnt", 64'(bc1), 64'(2));
        check("L2 bp buf_cnt", 64'(bc2), 64'(3));
        for (int d = 0; d < 2; d++) begin
            check($sformatf("L%0d bp rd_en", lat(d)), 64'(rd_en[d]), 64'd0);
            check($sformatf("L%0d bp tvalid", lat(d)), 64'(tvalid[d]), 64'd1);
            check($sformatf("L%0d bp tdata", lat(d)), 64'(tdata[d]), 64'h0);
        end
        drain("bp");

        // FIFO runs dry mid-burst, then one more word arrives.
        set_ready(1'b1);
        for (int i = 0; i < 3; i++) push(32'hA0 + 32'(i));
        repeat (12) step();
        push(32'hA3);
        ref_n = n;
        for (int d = 0; d < 2; d++) begin mark_on[d] = 1'b1; mark_n[d] = -1; end
        for (int i = 0; i < 20 && (mark_on[0] || mark_on[1]); i++) step();
        check("L1 refill_latency", 64'(mark_n[0] - ref_n), 64'(2));
        check("L2 refill_latency", 64'(mark_n[1] - ref_n), 64'(3));
        drain("dry");

        // Reset while a read is in flight: buffered and in-flight words are dropped.
        set_ready(1'b0);
        for (int i = 0; i < 4; i++) push(32'hC0 + 32'(i));
        for (int i = 0; i < 10 && issued[0] == arrived[0]; i++) step();
        check("L1 inflight_before_rst", 64'(issued[0] > arrived[0]), 64'd1);
        assert_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("L%0d rst tvalid", lat(d)), 64'(tvalid[d]), 64'd0);
            check($sformatf("L%0d rst tdata", lat(d)), 64'(tdata[d]), 64'd0);
            check($sformatf("L%0d rst buf_cnt", lat(d)), 64'(bcnt(d)), 64'd0);
            check($sformatf("L%0d rst rd_en", lat(d)), 64'(rd_en[d]), 64'd0);
        end
        repeat (3) step();
        rst = 1'b1;
        drain("rst");

        // Random payload with random backpressure.
        pushed = 0;
        for (int i = 0; i < 3000 && (pushed < 200 || accepted[0] != avail[0] || accepted[1] != avail[1]); i++) begin
            if (pushed < 200 && ($urandom % 3) != 0) begin
                push($urandom);
                pushed++;
            end
            set_ready(1'($urandom % 2));
            step();
        end
        drain("random");

`ifdef EASY_FIFO_AXIS_READER_STALL_CNT_EN
        // Stall counter: seven refused cycles, then it holds.
        assert_reset();
        step();
        rst = 1'b1;
        set_ready(1'b0);
        push(32'h55);
        for (int i = 0; i < 10 && arrived[1] == accepted[1]; i++) step();
        repeat (7) step();
        check("L1 stall7", 64'(sc[0]), 64'(stall_exp[0]));
        check("L2 stall7", 64'(sc[1]), 64'd7);
        set_ready(1'b1);
        repeat (3) step();
        check("L2 stall_hold", 64'(sc[1]), 64'd7);
        drain("stall");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
